// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction fetch port plus register file and ALU control lines
interface alu_seq_ctrl_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ack;
  logic [1:0]      rf_rs1_sel;
  logic [1:0]      rf_rs2_sel;
  logic [1:0]      rf_waddr;
  logic            rf_we;
  logic [2:0]      alu_op;
  logic            alu_en;
  logic            alu_is_zero;
  modport master (
    output imem_req, imem_addr, rf_rs1_sel, rf_rs2_sel, rf_waddr, rf_we, alu_op, alu_en,
    input  imem_rdata, imem_ack, alu_is_zero
  );
  modport slave (
    input  imem_req, imem_addr, rf_rs1_sel, rf_rs2_sel, rf_waddr, rf_we, alu_op, alu_en,
    output imem_rdata, imem_ack, alu_is_zero
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multicycle fetch/decode/exec sequencer driving an 8-bit ALU and 4x8 register file
module alu_seq_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  alu_seq_ctrl_if.master    bus,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              trap,
  output logic [CNT_W-1:0]  retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT, TRAP} state_t;
  state_t      state;
  logic [15:0] ir;
  logic [2:0]  op;
  logic        in_exec;
  logic        alu_class;
  logic        sel_live;
  assign op        = ir[15:13];
  assign in_exec   = state == EXEC;
  assign alu_class = op inside {3'b010, 3'b011, 3'b100};
  assign sel_live  = state inside {DECODE, EXEC};
  // Moore decode: every output is a pure function of state and ir, so all read 0 in IDLE
  assign bus.imem_req   = state == FETCH;
  assign bus.imem_addr  = state == FETCH ? pc : '0;
  assign bus.rf_rs1_sel = sel_live ? ir[10:9] : '0;
  assign bus.rf_rs2_sel = sel_live ? ir[8:7] : '0;
  assign bus.rf_we      = in_exec && alu_class;
  assign bus.rf_waddr   = bus.rf_we ? ir[12:11] : '0;
  assign bus.alu_en     = in_exec && (alu_class || op == 3'b001);
  assign bus.alu_op     = bus.alu_en ? op : '0;
  assign busy           = state inside {FETCH, DECODE, EXEC};
  assign halted         = state == HALT;
  assign trap           = state == TRAP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc    <= '0;
          state <= FETCH;
        end
        FETCH: if (bus.imem_ack) begin
          ir    <= bus.imem_rdata;
          state <= DECODE;
        end
        DECODE: state <= op == 3'b101 ? HALT : op[2:1] == 2'b11 ? TRAP : EXEC;
        EXEC: begin
          pc      <= (op == 3'b001 && bus.alu_is_zero) ? ir[PC_W-1:0] : pc + PC_W'(1);
          retired <= &retired ? retired : retired + CNT_W'(1);
          state   <= FETCH;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and randomized checks of alu_seq_ctrl against an instruction-level model
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  pc;
  logic        busy, halted, trap;
  logic [15:0] retired;
  alu_seq_ctrl_if #(.PC_W(8)) bus ();
  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .pc(pc), .busy(busy), .halted(halted), .trap(trap), .retired(retired)
  );
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [256];
  logic [7:0]  rf [4];
  logic [7:0]  mrf [4];
  int          ack_delay, wait_cnt, cyc;
  bit          rand_delay, jitter, force_ack;
  logic [7:0]  trace [$];
  logic [7:0]  mtrace [$];
  logic [7:0]  mpc, rf1_old;
  logic [15:0] mret;
  int          mstat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.imem_req, bus.imem_addr, bus.rf_rs1_sel, bus.rf_rs2_sel, bus.rf_waddr,
                bus.rf_we, bus.alu_op, bus.alu_en, pc, busy, halted, trap, retired});
  endfunction

  // Environment: instruction memory with programmable ack latency, register file and ALU
  task automatic drive_env();
    logic [7:0] a, b;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'($urandom);
    if (bus.imem_req) begin
      if (wait_cnt >= ack_delay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem[bus.imem_addr];
        trace.push_back(bus.imem_addr);
        wait_cnt  = 0;
        ack_delay = rand_delay ? int'($urandom_range(0, 3)) : 0;
      end else wait_cnt++;
    end
    if (force_ack) bus.imem_ack = 1'b1;
    a = rf[bus.rf_rs1_sel];
    b = rf[bus.rf_rs2_sel];
    bus.alu_is_zero = a == 8'd0;
    if (bus.rf_we)
      rf[bus.rf_waddr] = bus.alu_op == 3'd2 ? a + b : bus.alu_op == 3'd3 ? a & b : a ^ b;
    if (jitter) start = $urandom_range(0, 3) == 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_env();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; force_ack = 1'b0; jitter = 1'b0; rand_delay = 1'b0;
    ack_delay = 0; wait_cnt = 0;
    tick();
    rst = 1'b0;
    trace.delete();
  endtask

  // Architectural model: executes up to n instructions straight from the ISA rules
  task automatic model_run(input int n);
    logic [15:0] i;
    logic [2:0]  o;
    logic [7:0]  a, b;
    mpc = 0; mret = 0; mstat = 0; mtrace.delete();
    for (int k = 0; k < n && mstat == 0; k++) begin
      i = mem[mpc]; o = i[15:13]; a = mrf[i[10:9]]; b = mrf[i[8:7]];
      mtrace.push_back(mpc);
      if (o == 3'd5) mstat = 1;
      else if (o >= 3'd6) mstat = 2;
      else begin
        if (o == 3'd2) mrf[i[12:11]] = a + b;
        else if (o == 3'd3) mrf[i[12:11]] = a & b;
        else if (o == 3'd4) mrf[i[12:11]] = a ^ b;
        mpc = (o == 3'd1 && a == 8'd0) ? i[7:0] : mpc + 8'd1;
        mret++;
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    int r = $urandom_range(0, 19);
    logic [2:0] o = r < 3 ? 3'd0 : r < 7 ? 3'd1 : r < 10 ? 3'd2 : r < 13 ? 3'd3 : r < 16 ? 3'd4 :
                    r == 16 ? 3'd5 : r == 17 ? 3'd6 : r == 18 ? 3'd7 : 3'd2;
    return {o, 13'($urandom)};
  endfunction

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.alu_is_zero = 1'b0;
    foreach (mem[j]) mem[j] = 16'h0000;
    foreach (rf[j]) rf[j] = 8'd7;
    do_reset();
    chk("reset_outs", outs(), 0);
    repeat (10) begin
      tick();
      chk("idle_outs", outs(), 0);
    end

    // ADD, zero-wait fetch
    do_reset();
    mem[0] = 16'h4A80; mem[1] = 16'hA000; rf1_old = rf[1];
    start = 1'b1; tick(); start = 1'b0;
    chk("add_fetch", {bus.imem_req, bus.imem_addr, busy, bus.rf_we}, {1'b1, 8'h00, 1'b1, 1'b0});
    tick();
    chk("add_decode", {bus.rf_rs1_sel, bus.rf_rs2_sel, bus.rf_we, bus.alu_en, bus.imem_req},
        {2'd1, 2'd1, 1'b0, 1'b0, 1'b0});
    tick();
    chk("add_exec", {bus.alu_op, bus.alu_en, bus.rf_we, bus.rf_waddr, pc, retired},
        {3'b010, 1'b1, 1'b1, 2'd1, 8'd0, 16'd0});
    tick();
    chk("add_next_fetch", {bus.imem_req, bus.imem_addr, pc, retired}, {1'b1, 8'd1, 8'd1, 16'd1});
    chk("add_rf_result", rf[1], rf1_old + rf1_old);

    // Fetch stall of 4 cycles
    do_reset();
    mem[0] = 16'h4A80; ack_delay = 4;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_fetch", {bus.imem_req, bus.imem_addr, busy, bus.rf_rs1_sel}, {1'b1, 8'h00, 1'b1, 2'd0});
      tick();
    end
    chk("stall_decode", {bus.imem_req, bus.rf_rs1_sel, bus.rf_rs2_sel}, {1'b0, 2'd1, 2'd1});

    // JZ taken then not taken
    do_reset();
    rf[0] = 8'd0; mem[0] = 16'h2010; mem[16] = 16'h2010; mem[17] = 16'hA000;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("jz_decode_we", bus.rf_we, 0);
    tick();
    chk("jz_exec", {bus.alu_en, bus.alu_op, bus.rf_we, pc}, {1'b1, 3'b001, 1'b0, 8'd0});
    rf[0] = 8'd5;
    tick();
    chk("jz_taken_pc", {pc, bus.imem_addr, bus.rf_we}, {8'h10, 8'h10, 1'b0});
    tick();
    chk("jz2_decode_we", bus.rf_we, 0);
    tick();
    chk("jz2_exec", {bus.alu_en, bus.alu_op, bus.rf_we}, {1'b1, 3'b001, 1'b0});
    tick();
    chk("jz_not_taken_pc", {pc, retired, bus.rf_we}, {8'h11, 16'd2, 1'b0});

    // NOP then HALT; start and acks ignored afterwards
    do_reset();
    mem[0] = 16'h0000; mem[1] = 16'hA000;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("halt_state", {halted, busy, trap, pc, retired, bus.rf_we}, {1'b1, 1'b0, 1'b0, 8'd1, 16'd1, 1'b0});
    force_ack = 1'b1; start = 1'b1;
    repeat (20) begin
      tick();
      chk("halt_absorb", {halted, busy, pc, retired, bus.imem_req}, {1'b1, 1'b0, 8'd1, 16'd1, 1'b0});
    end
    force_ack = 1'b0; start = 1'b0;

    // Illegal opcode trap
    do_reset();
    mem[0] = 16'hE000;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("trap_state", {trap, halted, busy, pc, retired}, {1'b1, 1'b0, 1'b0, 8'd0, 16'd0});

    // PC wrap: jump to 255, NOP there, next fetch from 0
    do_reset();
    rf[0] = 8'd0; mem[0] = 16'h20FF; mem[255] = 16'h0000;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("wrap_fetch255", {bus.imem_req, bus.imem_addr}, {1'b1, 8'hFF});
    tick(); tick(); tick();
    chk("wrap_pc0", {bus.imem_req, bus.imem_addr, pc, retired}, {1'b1, 8'h00, 8'h00, 16'd2});

    // Reset during a fetch that is acked in the same cycle
    do_reset();
    mem[0] = 16'h4A80; mem[1] = 16'h4A80; mem[2] = 16'h4A80; mem[3] = 16'hA000;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!(bus.imem_req && retired == 16'd2) && cyc < 30) begin tick(); cyc++; end
    chk("midrst_reach", cyc < 30, 1);
    chk("midrst_ack_same_cycle", bus.imem_ack, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_outs", outs(), 0);
    tick();
    chk("midrst_outs_next", outs(), 0);

    // Randomized programs against the architectural model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      foreach (mem[j]) mem[j] = rand_instr();
      foreach (rf[j]) begin rf[j] = 8'($urandom_range(0, 3)); mrf[j] = rf[j]; end
      model_run(40);
      rand_delay = 1'b1; jitter = 1'b1; ack_delay = $urandom_range(0, 3);
      start = 1'b1; tick();
      cyc = 0;
      while (!(halted || trap || (bus.imem_req && retired == 16'd40)) && cyc < 400) begin tick(); cyc++; end
      jitter = 1'b0; start = 1'b0; rand_delay = 1'b0;
      chk("rand_budget", cyc < 400, 1);
      chk("rand_pc", pc, mpc);
      chk("rand_retired", retired, mret);
      chk("rand_status", {halted, trap}, {mstat == 1, mstat == 2});
      for (int j = 0; j < 4; j++) chk("rand_rf", rf[j], mrf[j]);
      chk("rand_trace_len", trace.size() >= mtrace.size(), 1);
      for (int j = 0; j < mtrace.size() && j < trace.size(); j++) chk("rand_trace", trace[j], mtrace[j]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
